// File: rtl/game_controller_pkg.sv
// rtl/game_controller_pkg.sv - shared state encoding, widths and defaults for the game controller
package game_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_INVULN = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam int SCORE_W = 10;
    localparam int LIVES_W = 2;
    localparam int TIMER_W = 8;

    localparam int LIVES_INIT_DEF    = 3;
    localparam int INVULN_FRAMES_DEF = 60;
    localparam int SCORE_MAX_DEF     = 999;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                    input logic [SCORE_W-1:0] cap);
        return (value >= cap) ? cap : value + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/game_controller_frame_timer.sv
// rtl/game_controller_frame_timer.sv - loadable frame-tick down-counter for the post-crash grace period
module frame_timer
    import game_controller_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && count != '0) begin
            count <= count - ONE;
        end
    end

    // Flags the last frame: the tick that arrives now ends the grace period.
    assign done = (count == ONE);

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - game FSM: score, lives, high score, grace period and respawn requests
module game_controller
    import game_controller_pkg::*;
#(
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF,
    parameter int SCORE_MAX     = SCORE_MAX_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               coin_hit,
    input  logic               police_hit,
    output logic               detect_en,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [LIVES_W-1:0] lives,
    output logic               respawn_coin,
    output logic               respawn_police,
    output logic               flash,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] SCORE_CAP   = SCORE_W'(SCORE_MAX);
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);
    localparam logic [TIMER_W-1:0] GRACE       = TIMER_W'(INVULN_FRAMES);

    state_t             state, state_next;
    logic [SCORE_W-1:0] score_next, high_next;
    logic [LIVES_W-1:0] lives_next;
    logic               coin_next, police_next;
    logic               detect_next, flash_next, over_next;
    logic               timer_load, timer_tick, timer_done;

    frame_timer #(.WIDTH(TIMER_W)) u_grace (
        .clk        (CLOCK_50),
        .rst        (reset),
        .load       (timer_load),
        .load_value (GRACE),
        .tick       (timer_tick),
        .done       (timer_done)
    );

    assign timer_tick = frame_tick && (state == ST_INVULN);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            score          <= '0;
            high_score     <= '0;
            lives          <= '0;
            respawn_coin   <= 1'b0;
            respawn_police <= 1'b0;
            detect_en      <= 1'b0;
            flash          <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            state          <= state_next;
            score          <= score_next;
            high_score     <= high_next;
            lives          <= lives_next;
            respawn_coin   <= coin_next;
            respawn_police <= police_next;
            detect_en      <= detect_next;
            flash          <= flash_next;
            game_over      <= over_next;
        end
    end

    always_comb begin
        state_next  = state;
        score_next  = score;
        lives_next  = lives;
        high_next   = high_score;
        coin_next   = 1'b0;
        police_next = 1'b0;
        timer_load  = 1'b0;
        unique case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_next = ST_PLAY;
                    score_next = '0;
                    lives_next = LIVES_START;
                end
            end
            ST_PLAY: begin
                if (coin_hit) begin
                    score_next = sat_inc(score, SCORE_CAP);
                    coin_next  = 1'b1;
                end
                if (police_hit) begin
                    police_next = 1'b1;
                    if (lives > LIVES_W'(1)) begin
                        lives_next = lives - LIVES_W'(1);
                        timer_load = 1'b1;
                        state_next = ST_INVULN;
                    end else begin
                        lives_next = '0;
                        state_next = ST_OVER;
                    end
                end
            end
            ST_INVULN: begin
                if (coin_hit) begin
                    score_next = sat_inc(score, SCORE_CAP);
                    coin_next  = 1'b1;
                end
                if (frame_tick && timer_done) begin
                    state_next = ST_PLAY;
                end
            end
        endcase
        // score_next already includes a coin taken on the fatal cycle.
        if (state_next == ST_OVER && state != ST_OVER && score_next > high_score) begin
            high_next = score_next;
        end
    end

    always_comb begin
        detect_next = (state_next == ST_PLAY) || (state_next == ST_INVULN);
        flash_next  = (state_next == ST_INVULN);
        over_next   = (state_next == ST_OVER);
    end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - table-driven scoreboard bench for game_controller
module tb_game_controller;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic       frame_tick;
    logic       coin_hit;
    logic       police_hit;
    logic       detect_en;
    logic [9:0] score;
    logic [9:0] high_score;
    logic [1:0] lives;
    logic       respawn_coin;
    logic       respawn_police;
    logic       flash;
    logic       game_over;

    game_controller dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .start          (start),
        .frame_tick     (frame_tick),
        .coin_hit       (coin_hit),
        .police_hit     (police_hit),
        .detect_en      (detect_en),
        .score          (score),
        .high_score     (high_score),
        .lives          (lives),
        .respawn_coin   (respawn_coin),
        .respawn_police (respawn_police),
        .flash          (flash),
        .game_over      (game_over)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       de;
        logic [9:0] sc;
        logic [9:0] hs;
        logic [1:0] lv;
        logic       rc;
        logic       rp;
        logic       fl;
        logic       go;
    } exp_t;

    typedef struct packed {
        logic s;
        logic c;
        logic p;
        logic t;
        exp_t e;
    } vec_t;

    exp_t  sb[$];
    string tag_q[$];
    vec_t  tbl[$];
    exp_t  mon_e;
    string mon_t;
    int    checks = 0;
    int    passed = 0;

    function automatic exp_t mk(logic de, int sc, int hs, int lv,
                                logic rc, logic rp, logic fl, logic go);
        exp_t e;
        e.de = de;
        e.sc = 10'(sc);
        e.hs = 10'(hs);
        e.lv = 2'(lv);
        e.rc = rc;
        e.rp = rp;
        e.fl = fl;
        e.go = go;
        return e;
    endfunction

    function automatic vec_t v(logic s, logic c, logic p, logic t, exp_t e);
        vec_t r;
        r.s = s;
        r.c = c;
        r.p = p;
        r.t = t;
        r.e = e;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cmp_all(string tag, exp_t e);
        chk({tag, " detect_en"},      int'(detect_en),      int'(e.de));
        chk({tag, " score"},          int'(score),          int'(e.sc));
        chk({tag, " high_score"},     int'(high_score),     int'(e.hs));
        chk({tag, " lives"},          int'(lives),          int'(e.lv));
        chk({tag, " respawn_coin"},   int'(respawn_coin),   int'(e.rc));
        chk({tag, " respawn_police"}, int'(respawn_police), int'(e.rp));
        chk({tag, " flash"},          int'(flash),          int'(e.fl));
        chk({tag, " game_over"},      int'(game_over),      int'(e.go));
    endtask

    // Inputs change 2 units after an edge; the expectation matures at the next edge.
    task automatic step(string tag, logic s, logic c, logic p, logic t, exp_t e);
        @(posedge CLOCK_50);
        #2;
        start      = s;
        coin_hit   = c;
        police_hit = p;
        frame_tick = t;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic run_tbl(string name);
        foreach (tbl[i]) begin
            step($sformatf("%s[%0d]", name, i), tbl[i].s, tbl[i].c, tbl[i].p, tbl[i].t, tbl[i].e);
        end
        tbl.delete();
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_t = tag_q.pop_front();
            cmp_all(mon_t, mon_e);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        frame_tick = 1'b0;
        coin_hit   = 1'b0;
        police_hit = 1'b0;
        #25;
        cmp_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLOCK_50);
        #2;
        reset = 1'b0;

        // IDLE ignores hits and ticks; start enters PLAY; start in PLAY ignored
        tbl.push_back(v(0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(1, 0, 0, 0, mk(1, 0, 0, 3, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, mk(1, 0, 0, 3, 0, 0, 0, 0)));
        tbl.push_back(v(1, 0, 0, 1, mk(1, 0, 0, 3, 0, 0, 0, 0)));
        run_tbl("idle_start");

        for (int k = 1; k <= 5; k++) begin
            step($sformatf("coin%0d", k),      0, 1, 0, 0, mk(1, k, 0, 3, 1, 0, 0, 0));
            step($sformatf("coin%0d_gap", k),  0, 0, 0, 0, mk(1, k, 0, 3, 0, 0, 0, 0));
        end

        step("crash1", 0, 0, 1, 0, mk(1, 5, 0, 2, 0, 1, 1, 0));
        for (int n = 1; n <= 10; n++) begin
            step($sformatf("grace_tick%0d", n), 0, 0, 0, 1, mk(1, 5, 0, 2, 0, 0, 1, 0));
            step($sformatf("grace_gap%0d", n),  0, 0, 0, 0, mk(1, 5, 0, 2, 0, 0, 1, 0));
        end

        // Second crash ignored during grace; coins still count
        tbl.push_back(v(0, 0, 1, 0, mk(1, 5, 0, 2, 0, 0, 1, 0)));
        tbl.push_back(v(0, 1, 0, 0, mk(1, 6, 0, 2, 1, 0, 1, 0)));
        tbl.push_back(v(0, 0, 0, 0, mk(1, 6, 0, 2, 0, 0, 1, 0)));
        run_tbl("invuln");

        for (int n = 11; n <= 60; n++) begin
            step($sformatf("grace_tick%0d", n), 0, 0, 0, 1, mk(1, 6, 0, 2, 0, 0, (n < 60), 0));
            step($sformatf("grace_gap%0d", n),  0, 0, 0, 0, mk(1, 6, 0, 2, 0, 0, (n < 60), 0));
        end

        step("crash2", 0, 0, 1, 0, mk(1, 6, 0, 1, 0, 1, 1, 0));
        for (int n = 1; n <= 60; n++) begin
            step($sformatf("grace2_tick%0d", n), 0, 0, 0, 1, mk(1, 6, 0, 1, 0, 0, (n < 60), 0));
        end

        // Fatal crash with a simultaneous coin, then OVER ignores hits, then restart
        tbl.push_back(v(0, 1, 1, 0, mk(0, 7, 7, 0, 1, 1, 0, 1)));
        tbl.push_back(v(0, 0, 0, 0, mk(0, 7, 7, 0, 0, 0, 0, 1)));
        tbl.push_back(v(0, 1, 1, 1, mk(0, 7, 7, 0, 0, 0, 0, 1)));
        tbl.push_back(v(1, 0, 0, 0, mk(1, 0, 7, 3, 0, 0, 0, 0)));
        run_tbl("over");

        for (int n = 1; n <= 1000; n++) begin
            step($sformatf("sat_coin%0d", n), 0, 1, 0, 0,
                 mk(1, (n < 999) ? n : 999, 7, 3, 1, 0, 0, 0));
        end
        step("sat_gap", 0, 0, 0, 0, mk(1, 999, 7, 3, 0, 0, 0, 0));

        step("crash3",     0, 0, 1, 0, mk(1, 999, 7, 2, 0, 1, 1, 0));
        step("crash3_gap", 0, 0, 0, 0, mk(1, 999, 7, 2, 0, 0, 1, 0));
        @(posedge CLOCK_50);
        #5;
        chk("scoreboard drained before reset", sb.size(), 0);
        reset = 1'b1;
        #1;
        cmp_all("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLOCK_50);
        #2;
        reset = 1'b0;

        tbl.push_back(v(1, 0, 0, 0, mk(1, 0, 0, 3, 0, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 0, mk(1, 1, 0, 3, 1, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, mk(1, 1, 0, 3, 0, 0, 0, 0)));
        run_tbl("fresh");

        @(posedge CLOCK_50);
        #5;
        chk("scoreboard drained at end", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
